// File: rtl/interrupt_acceptor_pkg.sv
// ----------------------------------------------------------------------------
// interrupt_acceptor_pkg : shared CPU package holding the interrupt FSM
// encoding and the external-interrupt cause code. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package interrupt_acceptor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PEND    = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_REDIR   = 3'd3,
    ST_HANDLER = 3'd4,
    ST_RET     = 3'd5
  } ia_state_e;

  localparam logic [31:0] MCAUSE_MEXT = 32'h8000_000B;

  // The handler is considered active from the flush until the return jump.
  function automatic logic ia_is_busy(input ia_state_e st);
    return (st == ST_FLUSH) || (st == ST_REDIR) ||
           (st == ST_HANDLER) || (st == ST_RET);
  endfunction

endpackage

`default_nettype wire

// File: rtl/interrupt_acceptor_if.sv
// ----------------------------------------------------------------------------
// interrupt_acceptor_if : CSR, pipeline and trap-control signals between the
// core and the interrupt acceptor. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface interrupt_acceptor_if;

  logic        g_interrupt;
  logic        csr_mie;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        pipe_stall;
  logic        cmd_mret;

  logic        int_flush;
  logic        int_jmp;
  logic [31:0] int_jmp_pc;
  logic        mepc_we;
  logic [31:0] mepc_wdata;
  logic        mcause_we;
  logic [31:0] mcause_wdata;
  logic        mstatus_trap;
  logic        mstatus_mret;
  logic        int_busy;

  modport master (
    output g_interrupt, csr_mie, csr_mtvec, csr_mepc, id_pc, id_valid,
           pipe_stall, cmd_mret,
    input  int_flush, int_jmp, int_jmp_pc, mepc_we, mepc_wdata, mcause_we,
           mcause_wdata, mstatus_trap, mstatus_mret, int_busy
  );

  modport slave (
    input  g_interrupt, csr_mie, csr_mtvec, csr_mepc, id_pc, id_valid,
           pipe_stall, cmd_mret,
    output int_flush, int_jmp, int_jmp_pc, mepc_we, mepc_wdata, mcause_we,
           mcause_wdata, mstatus_trap, mstatus_mret, int_busy
  );

endinterface

`default_nettype wire

// File: rtl/interrupt_acceptor.sv
// ----------------------------------------------------------------------------
// interrupt_acceptor : takes a machine external interrupt at a safe point,
// sequences flush / vector jump / MRET return. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module interrupt_acceptor
  import interrupt_acceptor_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         rst_n,
  interrupt_acceptor_if.slave bus
);

  ia_state_e   state_q, state_d;
  logic        pending_q, pending_d;
  logic        take_w;

  logic        int_flush_q;
  logic        int_jmp_q;
  logic [31:0] int_jmp_pc_q;
  logic        mepc_we_q;
  logic [31:0] mepc_wdata_q;
  logic        mcause_we_q;
  logic [31:0] mcause_wdata_q;
  logic        mstatus_trap_q;
  logic        mstatus_mret_q;
  logic        int_busy_q;

  assign take_w = (state_q == ST_PEND) && bus.csr_mie && bus.id_valid &&
                  !bus.pipe_stall;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (pending_q || bus.g_interrupt) state_d = ST_PEND;
      ST_PEND:    if (take_w) state_d = ST_FLUSH;
      ST_FLUSH:   state_d = ST_REDIR;
      ST_REDIR:   state_d = ST_HANDLER;
      ST_HANDLER: if (bus.cmd_mret) state_d = ST_RET;
      ST_RET:     state_d = pending_q ? ST_PEND : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A new request arriving in the same cycle as acceptance stays pending.
  assign pending_d = bus.g_interrupt ? 1'b1 : (take_w ? 1'b0 : pending_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      pending_q      <= 1'b0;
      int_flush_q    <= 1'b0;
      int_jmp_q      <= 1'b0;
      int_jmp_pc_q   <= 32'h0;
      mepc_we_q      <= 1'b0;
      mepc_wdata_q   <= 32'h0;
      mcause_we_q    <= 1'b0;
      mcause_wdata_q <= 32'h0;
      mstatus_trap_q <= 1'b0;
      mstatus_mret_q <= 1'b0;
      int_busy_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      int_flush_q    <= (state_d == ST_FLUSH);
      mepc_we_q      <= (state_d == ST_FLUSH);
      mcause_we_q    <= (state_d == ST_FLUSH);
      mstatus_trap_q <= (state_d == ST_FLUSH);
      int_jmp_q      <= (state_d == ST_REDIR) || (state_d == ST_RET);
      mstatus_mret_q <= (state_d == ST_RET);
      int_busy_q     <= ia_is_busy(state_d);
      if (take_w) begin
        mepc_wdata_q   <= bus.id_pc;
        mcause_wdata_q <= MCAUSE_MEXT;
      end
      if (state_d == ST_REDIR)
        int_jmp_pc_q <= bus.csr_mtvec & 32'hFFFF_FFFC;
      else if (state_d == ST_RET)
        int_jmp_pc_q <= bus.csr_mepc;
    end
  end

  assign bus.int_flush    = int_flush_q;
  assign bus.int_jmp      = int_jmp_q;
  assign bus.int_jmp_pc   = int_jmp_pc_q;
  assign bus.mepc_we      = mepc_we_q;
  assign bus.mepc_wdata   = mepc_wdata_q;
  assign bus.mcause_we    = mcause_we_q;
  assign bus.mcause_wdata = mcause_wdata_q;
  assign bus.mstatus_trap = mstatus_trap_q;
  assign bus.mstatus_mret = mstatus_mret_q;
  assign bus.int_busy     = int_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_acceptor.sv
// ----------------------------------------------------------------------------
// tb_interrupt_acceptor : directed and randomized checks of interrupt_acceptor
// against a cycle-level behavioural model. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_interrupt_acceptor;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  interrupt_acceptor_if u_if();

  interrupt_acceptor u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: m_pos is the position inside a trap sequence
  // (-1 none, 0 flush, 1 vector jump, 2 handler running, 3 return jump),
  // m_armed means a request is waiting for a safe point.
  int          m_pos;
  bit          m_armed;
  bit          m_req;
  logic [31:0] m_mepc;
  logic [31:0] m_jpc;

  task automatic model_reset();
    m_pos = -1; m_armed = 1'b0; m_req = 1'b0; m_mepc = 32'h0; m_jpc = 32'h0;
  endtask

  task automatic model_update();
    bit g, take;
    g    = u_if.g_interrupt;
    take = (m_pos < 0) && m_armed && u_if.csr_mie && u_if.id_valid && !u_if.pipe_stall;
    if (m_pos < 0) begin
      if (take) begin
        m_pos = 0; m_armed = 1'b0; m_mepc = u_if.id_pc;
      end else if (!m_armed && (m_req || g)) begin
        m_armed = 1'b1;
      end
    end else if (m_pos == 0) begin
      m_pos = 1; m_jpc = {u_if.csr_mtvec[31:2], 2'b00};
    end else if (m_pos == 1) begin
      m_pos = 2;
    end else if (m_pos == 2) begin
      if (u_if.cmd_mret) begin m_pos = 3; m_jpc = u_if.csr_mepc; end
    end else begin
      m_pos = -1; m_armed = m_req;
    end
    m_req = g || (m_req && !take);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_idle_inputs();
    u_if.g_interrupt = 1'b0; u_if.csr_mie = 1'b1; u_if.csr_mtvec = 32'h0000_0803;
    u_if.csr_mepc = 32'h0000_0120; u_if.id_pc = 32'h0000_0120; u_if.id_valid = 1'b1;
    u_if.pipe_stall = 1'b0; u_if.cmd_mret = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (3) step();
    tests_run++;
    if ({u_if.int_flush, u_if.int_jmp, u_if.mepc_we, u_if.mcause_we, u_if.mstatus_trap,
         u_if.mstatus_mret, u_if.int_busy} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_strobes got=%b exp=0", {u_if.int_flush, u_if.int_jmp, u_if.mepc_we,
               u_if.mcause_we, u_if.mstatus_trap, u_if.mstatus_mret, u_if.int_busy});
    end
    tests_run++;
    if ({u_if.int_jmp_pc, u_if.mepc_wdata, u_if.mcause_wdata} !== 96'h0) begin
      tests_failed++;
      $display("FAIL reset_buses got=%h exp=0", {u_if.int_jmp_pc, u_if.mepc_wdata, u_if.mcause_wdata});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    tests_run++;
    if ({u_if.int_flush, u_if.int_busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_no_action got=%b exp=00", {u_if.int_flush, u_if.int_busy});
    end
  endtask

  task automatic finish_handler();
    u_if.cmd_mret = 1'b1;
    step();
    u_if.cmd_mret = 1'b0;
    step();
  endtask

  task automatic test_basic();
    drive_idle_inputs();
    u_if.g_interrupt = 1'b1;
    step();
    u_if.g_interrupt = 1'b0;
    tests_run++;
    if (u_if.int_flush !== 1'b0) begin
      tests_failed++; $display("FAIL basic_flush_early got=%b exp=0", u_if.int_flush);
    end
    step();
    tests_run++;
    if ({u_if.int_flush, u_if.mepc_we, u_if.mcause_we, u_if.mstatus_trap, u_if.int_busy, u_if.int_jmp}
        !== 6'b111110) begin
      tests_failed++;
      $display("FAIL basic_flush got=%b exp=111110", {u_if.int_flush, u_if.mepc_we, u_if.mcause_we,
               u_if.mstatus_trap, u_if.int_busy, u_if.int_jmp});
    end
    tests_run++;
    if ({u_if.mepc_wdata, u_if.mcause_wdata} !== {32'h0000_0120, 32'h8000_000B}) begin
      tests_failed++;
      $display("FAIL basic_trap_data got=%h/%h exp=00000120/8000000b", u_if.mepc_wdata, u_if.mcause_wdata);
    end
    step();
    tests_run++;
    if ({u_if.int_jmp, u_if.int_flush, u_if.int_jmp_pc} !== {2'b10, 32'h0000_0800}) begin
      tests_failed++;
      $display("FAIL basic_vector got jmp=%b flush=%b pc=%h exp jmp=1 flush=0 pc=00000800",
               u_if.int_jmp, u_if.int_flush, u_if.int_jmp_pc);
    end
    step();
    tests_run++;
    if ({u_if.int_jmp, u_if.int_busy} !== 2'b01) begin
      tests_failed++; $display("FAIL basic_handler got=%b exp=01", {u_if.int_jmp, u_if.int_busy});
    end
    finish_handler();
    tests_run++;
    if (u_if.int_busy !== 1'b0) begin
      tests_failed++; $display("FAIL basic_return_idle got=%b exp=0", u_if.int_busy);
    end
  endtask

  task automatic test_mie_gate();
    drive_idle_inputs();
    u_if.csr_mie = 1'b0;
    u_if.g_interrupt = 1'b1;
    step();
    u_if.g_interrupt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      tests_run++;
      if (u_if.int_flush !== 1'b0 || u_if.int_busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL mie_hold cycle=%0d got flush=%b busy=%b exp 0 0", i, u_if.int_flush, u_if.int_busy);
      end
    end
    u_if.csr_mie = 1'b1;
    step();
    tests_run++;
    if (u_if.int_flush !== 1'b1) begin
      tests_failed++; $display("FAIL mie_release got=%b exp=1", u_if.int_flush);
    end
    step(); step();
    finish_handler();
  endtask

  task automatic test_nesting();
    drive_idle_inputs();
    u_if.g_interrupt = 1'b1;
    step();
    u_if.g_interrupt = 1'b0;
    step(); step(); step();
    u_if.csr_mie = 1'b0;
    u_if.g_interrupt = 1'b1;
    step();
    u_if.g_interrupt = 1'b0;
    step();
    tests_run++;
    if ({u_if.int_busy, u_if.int_flush, u_if.int_jmp} !== 3'b100) begin
      tests_failed++;
      $display("FAIL nest_no_reentry got=%b exp=100", {u_if.int_busy, u_if.int_flush, u_if.int_jmp});
    end
    u_if.csr_mepc = 32'h0000_0120;
    u_if.cmd_mret = 1'b1;
    step();
    u_if.cmd_mret = 1'b0;
    tests_run++;
    if ({u_if.int_jmp, u_if.mstatus_mret, u_if.int_jmp_pc} !== {2'b11, 32'h0000_0120}) begin
      tests_failed++;
      $display("FAIL nest_mret got jmp=%b mret=%b pc=%h exp 1 1 00000120",
               u_if.int_jmp, u_if.mstatus_mret, u_if.int_jmp_pc);
    end
    repeat (3) step();
    tests_run++;
    if ({u_if.int_busy, u_if.int_flush, u_if.int_jmp, u_if.mstatus_mret} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL nest_pend_hold got=%b exp=0000",
               {u_if.int_busy, u_if.int_flush, u_if.int_jmp, u_if.mstatus_mret});
    end
    u_if.csr_mie = 1'b1;
    step();
    tests_run++;
    if (u_if.int_flush !== 1'b1) begin
      tests_failed++; $display("FAIL nest_second_entry got=%b exp=1", u_if.int_flush);
    end
    step(); step();
    finish_handler();
  endtask

  task automatic test_stall();
    drive_idle_inputs();
    u_if.pipe_stall = 1'b1;
    u_if.g_interrupt = 1'b1;
    step();
    u_if.g_interrupt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (u_if.int_flush !== 1'b0) begin
        tests_failed++; $display("FAIL stall_hold cycle=%0d got=%b exp=0", i, u_if.int_flush);
      end
    end
    u_if.pipe_stall = 1'b0;
    step();
    tests_run++;
    if (u_if.int_flush !== 1'b1) begin
      tests_failed++; $display("FAIL stall_release got=%b exp=1", u_if.int_flush);
    end
    step(); step();
    finish_handler();
  endtask

  task automatic test_reset_in_handler();
    drive_idle_inputs();
    u_if.g_interrupt = 1'b1;
    step();
    u_if.g_interrupt = 1'b0;
    step(); step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if ({u_if.int_flush, u_if.int_jmp, u_if.int_busy, u_if.mstatus_trap, u_if.mstatus_mret,
         u_if.int_jmp_pc, u_if.mepc_wdata, u_if.mcause_wdata} !== 101'h0) begin
      tests_failed++;
      $display("FAIL async_reset got busy=%b jmp=%b pc=%h mepc=%h mcause=%h exp all 0",
               u_if.int_busy, u_if.int_jmp, u_if.int_jmp_pc, u_if.mepc_wdata, u_if.mcause_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    u_if.cmd_mret = 1'b1;
    step();
    u_if.cmd_mret = 1'b0;
    repeat (3) step();
    tests_run++;
    if ({u_if.int_jmp, u_if.mstatus_mret, u_if.int_busy, u_if.int_flush} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL post_reset_mret got=%b exp=0000",
               {u_if.int_jmp, u_if.mstatus_mret, u_if.int_busy, u_if.int_flush});
    end
  endtask

  task automatic test_mret_idle();
    drive_idle_inputs();
    u_if.cmd_mret = 1'b1;
    step();
    u_if.cmd_mret = 1'b0;
    tests_run++;
    if ({u_if.int_jmp, u_if.mstatus_mret} !== 2'b00) begin
      tests_failed++;
      $display("FAIL idle_mret got=%b exp=00", {u_if.int_jmp, u_if.mstatus_mret});
    end
  endtask

  task automatic test_random();
    logic [6:0] exp_s, got_s;
    for (int i = 0; i < 600; i++) begin
      u_if.g_interrupt = ($urandom_range(0, 5) == 0);
      u_if.csr_mie     = ($urandom_range(0, 3) != 0);
      u_if.id_valid    = ($urandom_range(0, 4) != 0);
      u_if.pipe_stall  = ($urandom_range(0, 3) == 0);
      u_if.cmd_mret    = ($urandom_range(0, 5) == 0);
      u_if.id_pc       = $urandom & 32'hFFFF_FFFC;
      u_if.csr_mtvec   = $urandom;
      u_if.csr_mepc    = $urandom & 32'hFFFF_FFFC;
      step();
      exp_s = {m_pos == 0, m_pos == 0, m_pos == 0, m_pos == 0,
               (m_pos == 1) || (m_pos == 3), m_pos == 3, m_pos >= 0};
      got_s = {u_if.int_flush, u_if.mepc_we, u_if.mcause_we, u_if.mstatus_trap,
               u_if.int_jmp, u_if.mstatus_mret, u_if.int_busy};
      tests_run++;
      if (got_s !== exp_s) begin
        tests_failed++; $display("FAIL rand_strobes cycle=%0d got=%b exp=%b", i, got_s, exp_s);
      end
      if (m_pos == 0) begin
        tests_run++;
        if ({u_if.mepc_wdata, u_if.mcause_wdata} !== {m_mepc, 32'h8000_000B}) begin
          tests_failed++;
          $display("FAIL rand_trap_data cycle=%0d got=%h/%h exp=%h/8000000b",
                   i, u_if.mepc_wdata, u_if.mcause_wdata, m_mepc);
        end
      end
      if (m_pos == 1 || m_pos == 3) begin
        tests_run++;
        if (u_if.int_jmp_pc !== m_jpc) begin
          tests_failed++; $display("FAIL rand_jmp_pc cycle=%0d got=%h exp=%h", i, u_if.int_jmp_pc, m_jpc);
        end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    drive_idle_inputs();
    model_reset();
    test_reset();
    test_basic();
    test_mie_gate();
    test_nesting();
    test_stall();
    test_reset_in_handler();
    test_mret_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
